// File: rtl/adc_dac_pkg.sv
// ----------------------------------------------------------------------------
// adc_dac_pkg
// Shared types and sizing helpers for the ADC/DAC sample scheduler.
//   state_e      : scheduler FSM states
//   cnt_width()  : bits needed for a counter that runs 0..n-1 (minimum 1)
//   presc_width(): bits needed for the 1 ms prescaler at a given clock rate
// ----------------------------------------------------------------------------
package adc_dac_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRIG    = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_e;

   function automatic int unsigned cnt_width(input longint unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < n) w++;
      return w;
   endfunction

   function automatic int unsigned presc_width(input longint unsigned sys_clk_freq);
      return cnt_width(sys_clk_freq / 1000);
   endfunction

endpackage

// File: rtl/adc_dac_sample_sched_ms_tick_gen.sv
// ----------------------------------------------------------------------------
// ms_tick_gen
// Millisecond prescaler followed by a period counter. Emits a one-cycle
// per_req every SAMPLE_PERIOD_MS milliseconds while run is high; both
// counters are held at zero while run is low, so the first request arrives a
// full period after run rises.
// Ports:
//   sclk     in   system clock
//   nrst     in   asynchronous active-low reset
//   run      in   counters advance only while high
//   per_req  out  one-cycle periodic request
// ----------------------------------------------------------------------------
module ms_tick_gen
   import adc_dac_pkg::*;
#(
   parameter int unsigned SYS_CLK_FREQ     = 50_000_000,
   parameter int unsigned SAMPLE_PERIOD_MS = 100
) (
   input  logic sclk,
   input  logic nrst,
   input  logic run,
   output logic per_req
);

   localparam int unsigned DIV = SYS_CLK_FREQ / 1000;
   localparam int unsigned PW  = presc_width(SYS_CLK_FREQ);
   localparam int unsigned QW  = cnt_width(SAMPLE_PERIOD_MS);

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [QW-1:0] PER_LAST   = QW'(SAMPLE_PERIOD_MS - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [QW-1:0] per_cnt_q, per_cnt_d;
   logic          per_req_q, per_req_d;
   logic          ms_tick;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      ms_tick   = run && (presc_q == PRESC_LAST);
      presc_d   = presc_q;
      per_cnt_d = per_cnt_q;
      per_req_d = 1'b0;

      if (!run) begin
         presc_d   = '0;
         per_cnt_d = '0;
      end else begin
         presc_d = ms_tick ? '0 : presc_q + 1'b1;
         if (ms_tick) begin
            if (per_cnt_q == PER_LAST) begin
               per_cnt_d = '0;
               per_req_d = 1'b1;
            end else begin
               per_cnt_d = per_cnt_q + 1'b1;
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         presc_q   <= '0;
         per_cnt_q <= '0;
         per_req_q <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         per_cnt_q <= per_cnt_d;
         per_req_q <= per_req_d;
      end
   end

   assign per_req = per_req_q;

endmodule

// File: rtl/adc_dac_sample_sched.sv
// ----------------------------------------------------------------------------
// adc_dac_sample_sched
// Sequencer for the ADC081C021/DAC5571 I2C transfer engine. Decides when to
// start a transfer (periodic timer in auto mode, or a debounced key pulse),
// waits for completion with a timeout, captures the returned voltage code,
// keeps a 2^AVG_SHIFT block average and counts successful samples.
// Ports:
//   sclk, nrst     clock, asynchronous active-low reset
//   en, auto_mode  scheduler enable, periodic triggering select
//   man_trig       single-cycle manual request
//   gs_trig        one-cycle start pulse to the I2C engine
//   gs_done/vol_in completion pulse and voltage code from the engine
//   vol_out/vol_valid  last captured sample and its update strobe
//   vol_avg/avg_valid  last block average and its update strobe
//   busy           high while a transfer is in progress (TRIG..CAPTURE)
//   timeout_err    sticky timeout flag, cleared by err_clr
//   sample_cnt     successful capture count, wraps
// ----------------------------------------------------------------------------
module adc_dac_sample_sched
   import adc_dac_pkg::*;
#(
   parameter int unsigned SYS_CLK_FREQ     = 50_000_000,
   parameter int unsigned SAMPLE_PERIOD_MS = 100,
   parameter int unsigned TIMEOUT_CYCLES   = 2_000_000,
   parameter int unsigned AVG_SHIFT        = 3
) (
   input  logic        sclk,
   input  logic        nrst,
   input  logic        en,
   input  logic        auto_mode,
   input  logic        man_trig,
   output logic        gs_trig,
   input  logic        gs_done,
   input  logic [7:0]  vol_in,
   output logic [7:0]  vol_out,
   output logic [7:0]  vol_avg,
   output logic        vol_valid,
   output logic        avg_valid,
   output logic        busy,
   output logic        timeout_err,
   input  logic        err_clr,
   output logic [15:0] sample_cnt
);

   localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
   localparam int unsigned AW = 8 + AVG_SHIFT;
   localparam int unsigned BW = (AVG_SHIFT == 0) ? 1 : AVG_SHIFT;

   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'((1 << AVG_SHIFT) - 1);

   state_e        state_q, state_d;
   logic          req_q, req_d;
   logic          pending_q, pending_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [BW-1:0] blk_cnt_q, blk_cnt_d;
   logic [7:0]    vol_out_q, vol_out_d;
   logic [7:0]    vol_avg_q, vol_avg_d;
   logic          vol_valid_q, vol_valid_d;
   logic          avg_valid_q, avg_valid_d;
   logic          busy_q, busy_d;
   logic          gs_trig_q, gs_trig_d;
   logic          timeout_err_q, timeout_err_d;
   logic [15:0]   sample_cnt_q, sample_cnt_d;

   logic          per_req;
   logic          timeout;
   logic [TW-1:0] to_inc;
   logic [AW-1:0] acc_sum;

   ms_tick_gen #(
      .SYS_CLK_FREQ     (SYS_CLK_FREQ),
      .SAMPLE_PERIOD_MS (SAMPLE_PERIOD_MS)
   ) u_tick (
      .sclk    (sclk),
      .nrst    (nrst),
      .run     (en & auto_mode),
      .per_req (per_req)
   );

   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      to_cnt_d      = to_cnt_q;
      acc_d         = acc_q;
      blk_cnt_d     = blk_cnt_q;
      vol_out_d     = vol_out_q;
      vol_avg_d     = vol_avg_q;
      avg_valid_d   = 1'b0;
      timeout_err_d = timeout_err_q;
      sample_cnt_d  = sample_cnt_q;
      timeout       = 1'b0;

      // Requests are registered once; IDLE acts on the registered copy, which
      // gives the two-cycle man_trig -> gs_trig latency.
      req_d   = en & (man_trig | per_req);
      to_inc  = to_cnt_q + 1'b1;
      acc_sum = acc_q + AW'(vol_in);

      unique case (state_q)
         IDLE: begin
            if ((req_q | pending_q) & en) state_d = TRIG;
         end
         TRIG: begin
            to_cnt_d = '0;
            state_d  = WAIT;
         end
         WAIT: begin
            to_cnt_d = to_inc;
            if (gs_done) begin
               // Capture bookkeeping is done on the way into CAPTURE so the
               // registered strobes, sample, count and average all become
               // visible together during the CAPTURE cycle.
               vol_out_d    = vol_in;
               sample_cnt_d = sample_cnt_q + 16'd1;
               if (blk_cnt_q == BLK_LAST) begin
                  vol_avg_d   = 8'(acc_sum >> AVG_SHIFT);
                  avg_valid_d = 1'b1;
                  acc_d       = '0;
                  blk_cnt_d   = '0;
               end else begin
                  acc_d     = acc_sum;
                  blk_cnt_d = blk_cnt_q + 1'b1;
               end
               state_d = CAPTURE;
            end else if (to_inc == TO_LAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Single-deep pending bit: requests arriving while busy coalesce here.
      if (!en) begin
         pending_d = 1'b0;
      end else if ((state_q == IDLE) && (req_q | pending_q)) begin
         pending_d = 1'b0;
      end else if (req_q) begin
         pending_d = 1'b1;
      end

      // A timeout in the same cycle as err_clr wins.
      if (timeout) begin
         timeout_err_d = 1'b1;
      end else if (err_clr) begin
         timeout_err_d = 1'b0;
      end

      gs_trig_d   = (state_d == TRIG);
      busy_d      = (state_d != IDLE);
      vol_valid_d = (state_d == CAPTURE);
   end

   always_ff @(posedge sclk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= IDLE;
         req_q         <= 1'b0;
         pending_q     <= 1'b0;
         to_cnt_q      <= '0;
         acc_q         <= '0;
         blk_cnt_q     <= '0;
         vol_out_q     <= '0;
         vol_avg_q     <= '0;
         vol_valid_q   <= 1'b0;
         avg_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         gs_trig_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         sample_cnt_q  <= '0;
      end else begin
         state_q       <= state_d;
         req_q         <= req_d;
         pending_q     <= pending_d;
         to_cnt_q      <= to_cnt_d;
         acc_q         <= acc_d;
         blk_cnt_q     <= blk_cnt_d;
         vol_out_q     <= vol_out_d;
         vol_avg_q     <= vol_avg_d;
         vol_valid_q   <= vol_valid_d;
         avg_valid_q   <= avg_valid_d;
         busy_q        <= busy_d;
         gs_trig_q     <= gs_trig_d;
         timeout_err_q <= timeout_err_d;
         sample_cnt_q  <= sample_cnt_d;
      end
   end

   assign gs_trig     = gs_trig_q;
   assign busy        = busy_q;
   assign vol_out     = vol_out_q;
   assign vol_avg     = vol_avg_q;
   assign vol_valid   = vol_valid_q;
   assign avg_valid   = avg_valid_q;
   assign timeout_err = timeout_err_q;
   assign sample_cnt  = sample_cnt_q;

endmodule

// File: tb/tb_adc_dac_sample_sched.sv
// ----------------------------------------------------------------------------
// tb_adc_dac_sample_sched
// Directed bench for adc_dac_sample_sched with a 10 kHz clock (10 cycles per
// ms), 3 ms period, 50-cycle timeout and 4-sample averaging. Inputs change and
// outputs are sampled on the falling edge of sclk.
// ----------------------------------------------------------------------------
module tb_adc_dac_sample_sched;

   logic        sclk;
   logic        nrst;
   logic        en;
   logic        auto_mode;
   logic        man_trig;
   logic        gs_trig;
   logic        gs_done;
   logic [7:0]  vol_in;
   logic [7:0]  vol_out;
   logic [7:0]  vol_avg;
   logic        vol_valid;
   logic        avg_valid;
   logic        busy;
   logic        timeout_err;
   logic        err_clr;
   logic [15:0] sample_cnt;

   int errors = 0;
   int checks = 0;
   int trig_cnt = 0;

   adc_dac_sample_sched #(
      .SYS_CLK_FREQ     (10_000),
      .SAMPLE_PERIOD_MS (3),
      .TIMEOUT_CYCLES   (50),
      .AVG_SHIFT        (2)
   ) dut (
      .sclk        (sclk),
      .nrst        (nrst),
      .en          (en),
      .auto_mode   (auto_mode),
      .man_trig    (man_trig),
      .gs_trig     (gs_trig),
      .gs_done     (gs_done),
      .vol_in      (vol_in),
      .vol_out     (vol_out),
      .vol_avg     (vol_avg),
      .vol_valid   (vol_valid),
      .avg_valid   (avg_valid),
      .busy        (busy),
      .timeout_err (timeout_err),
      .err_clr     (err_clr),
      .sample_cnt  (sample_cnt)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   always @(negedge sclk) if (gs_trig === 1'b1) trig_cnt++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      nrst     = 1'b0;
      man_trig = 1'b0;
      gs_done  = 1'b0;
      err_clr  = 1'b0;
      vol_in   = 8'h00;
      @(negedge sclk);
      nrst = 1'b1;
      @(negedge sclk);
   endtask

   task automatic pulse_man();
      man_trig = 1'b1;
      @(negedge sclk);
      man_trig = 1'b0;
   endtask

   // Counts falling edges (the current one is 1) until gs_trig is seen.
   task automatic wait_trig(input int limit, output int n);
      n = 1;
      while (gs_trig !== 1'b1 && n < limit) begin
         @(negedge sclk);
         n++;
      end
      if (gs_trig !== 1'b1) n = -1;
   endtask

   // Called on the edge where gs_trig is seen; answers after lat cycles and
   // returns on the edge where vol_valid is expected.
   task automatic finish_xfer(input logic [7:0] val, input int lat);
      repeat (lat) @(negedge sclk);
      gs_done = 1'b1;
      vol_in  = val;
      @(negedge sclk);
      gs_done = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge sclk);
      checks++;
      if ({gs_trig, busy, vol_valid, avg_valid, timeout_err} !== 5'b0 ||
          vol_out !== 8'h00 || vol_avg !== 8'h00 || sample_cnt !== 16'h0) begin
         $display("FAIL reset_state: trig=%b busy=%b vv=%b av=%b err=%b out=%h avg=%h cnt=%0d, all zero required",
                  gs_trig, busy, vol_valid, avg_valid, timeout_err, vol_out, vol_avg, sample_cnt);
         errors++;
      end
      nrst = 1'b1;
      @(negedge sclk);
   endtask

   task automatic test_manual();
      int n;
      int busy_n;
      en = 1'b1;
      auto_mode = 1'b0;
      pulse_man();
      wait_trig(10, n);
      checks++;
      if (n !== 2) begin
         $display("FAIL man_latency: got %0d cycles, expected 2", n);
         errors++;
      end
      busy_n = 0;
      for (int c = 0; c < 10; c++) begin
         if (busy === 1'b1) busy_n++;
         @(negedge sclk);
      end
      checks++;
      if (vol_valid !== 1'b0) begin
         $display("FAIL man_early_valid: vol_valid=%b before gs_done, expected 0", vol_valid);
         errors++;
      end
      gs_done = 1'b1;
      vol_in  = 8'h5A;
      if (busy === 1'b1) busy_n++;
      @(negedge sclk);
      gs_done = 1'b0;
      checks++;
      if (vol_valid !== 1'b1 || vol_out !== 8'h5A || sample_cnt !== 16'd1) begin
         $display("FAIL man_capture: vv=%b out=%h cnt=%0d, expected 1/5a/1", vol_valid, vol_out, sample_cnt);
         errors++;
      end
      if (busy === 1'b1) busy_n++;
      @(negedge sclk);
      checks++;
      if (vol_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL man_after: vv=%b busy=%b, expected 0/0", vol_valid, busy);
         errors++;
      end
      checks++;
      if (busy_n !== 12) begin
         $display("FAIL man_busy_len: busy %0d cycles, expected 12", busy_n);
         errors++;
      end
   endtask

   task automatic test_average();
      logic [7:0] smp [8] = '{8'h10, 8'h20, 8'h30, 8'h41, 8'h04, 8'h04, 8'h04, 8'h08};
      logic [7:0] avg [2] = '{8'h28, 8'h05};
      int n;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pulse_man();
         wait_trig(10, n);
         finish_xfer(smp[i], 4);
         checks++;
         if (vol_valid !== 1'b1 || vol_out !== smp[i] || avg_valid !== (i % 4 == 3)) begin
            $display("FAIL avg_sample%0d: vv=%b out=%h av=%b, expected 1/%h/%b",
                     i, vol_valid, vol_out, avg_valid, smp[i], (i % 4 == 3));
            errors++;
         end
         if (i % 4 == 3 || i == 4) begin
            checks++;
            if (vol_avg !== avg[(i == 4) ? 0 : i / 4]) begin
               $display("FAIL avg_value%0d: vol_avg=%h, expected %h", i, vol_avg, avg[(i == 4) ? 0 : i / 4]);
               errors++;
            end
         end
      end
      @(negedge sclk);
      checks++;
      if (avg_valid !== 1'b0 || sample_cnt !== 16'd8) begin
         $display("FAIL avg_after: av=%b cnt=%0d, expected 0/8", avg_valid, sample_cnt);
         errors++;
      end
   endtask

   task automatic test_pending();
      int n;
      int snap;
      do_reset();
      pulse_man();
      wait_trig(10, n);
      repeat (3) begin
         pulse_man();
         @(negedge sclk);
      end
      repeat (4) @(negedge sclk);
      gs_done = 1'b1;
      vol_in  = 8'h33;
      @(negedge sclk);
      gs_done = 1'b0;
      checks++;
      if (vol_valid !== 1'b1 || vol_out !== 8'h33) begin
         $display("FAIL pend_first: vv=%b out=%h, expected 1/33", vol_valid, vol_out);
         errors++;
      end
      wait_trig(10, n);
      checks++;
      if (n !== 3) begin
         $display("FAIL pend_trig_delay: trig %0d edges after capture, expected 3", n);
         errors++;
      end
      finish_xfer(8'h44, 3);
      snap = trig_cnt;
      repeat (40) @(negedge sclk);
      checks++;
      if (trig_cnt !== snap || sample_cnt !== 16'd2) begin
         $display("FAIL pend_coalesce: extra trigs=%0d cnt=%0d, expected 0/2", trig_cnt - snap, sample_cnt);
         errors++;
      end
   endtask

   task automatic test_auto_period();
      int tc[$];
      int due;
      int snap;
      do_reset();
      en = 1'b1;
      auto_mode = 1'b1;
      due = -1;
      for (int c = 0; c < 200; c++) begin
         @(negedge sclk);
         gs_done = 1'b0;
         if (c == due) begin
            gs_done = 1'b1;
            vol_in  = 8'(c);
         end
         if (gs_trig === 1'b1) begin
            tc.push_back(c);
            due = c + 5;
         end
      end
      gs_done = 1'b0;
      checks++;
      if (tc.size() !== 6) begin
         $display("FAIL auto_count: %0d triggers, expected 6", tc.size());
         errors++;
      end
      checks++;
      if (tc.size() == 0 || tc[0] !== 31) begin
         $display("FAIL auto_first: first trigger at %0d, expected 31", (tc.size() == 0) ? -1 : tc[0]);
         errors++;
      end
      for (int i = 1; i < tc.size(); i++) begin
         checks++;
         if (tc[i] - tc[i-1] !== 30) begin
            $display("FAIL auto_gap%0d: %0d cycles, expected 30", i, tc[i] - tc[i-1]);
            errors++;
         end
      end
      checks++;
      if (sample_cnt !== 16'd6) begin
         $display("FAIL auto_samples: cnt=%0d, expected 6", sample_cnt);
         errors++;
      end
      en = 1'b0;
      snap = trig_cnt;
      repeat (100) @(negedge sclk);
      checks++;
      if (trig_cnt !== snap) begin
         $display("FAIL auto_disabled: %0d triggers with en=0, expected 0", trig_cnt - snap);
         errors++;
      end
      en = 1'b1;
      auto_mode = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      pulse_man();
      wait_trig(10, n);
      finish_xfer(8'h77, 5);
      pulse_man();
      wait_trig(10, n);
      repeat (49) @(negedge sclk);
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         $display("FAIL to_early: err=%b busy=%b at 49 cycles, expected 0/1", timeout_err, busy);
         errors++;
      end
      @(negedge sclk);
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0 || vol_out !== 8'h77 || sample_cnt !== 16'd1) begin
         $display("FAIL to_set: err=%b busy=%b out=%h cnt=%0d, expected 1/0/77/1",
                  timeout_err, busy, vol_out, sample_cnt);
         errors++;
      end
      gs_done = 1'b1;
      vol_in  = 8'hEE;
      @(negedge sclk);
      gs_done = 1'b0;
      @(negedge sclk);
      checks++;
      if (vol_valid !== 1'b0 || vol_out !== 8'h77 || busy !== 1'b0 || timeout_err !== 1'b1) begin
         $display("FAIL to_late_done: vv=%b out=%h busy=%b err=%b, expected 0/77/0/1",
                  vol_valid, vol_out, busy, timeout_err);
         errors++;
      end
      err_clr = 1'b1;
      @(negedge sclk);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         $display("FAIL to_clear: err=%b, expected 0", timeout_err);
         errors++;
      end
      pulse_man();
      wait_trig(10, n);
      repeat (49) @(negedge sclk);
      err_clr = 1'b1;
      @(negedge sclk);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b1) begin
         $display("FAIL to_set_priority: err=%b with err_clr at timeout, expected 1", timeout_err);
         errors++;
      end
      err_clr = 1'b1;
      @(negedge sclk);
      err_clr = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         $display("FAIL to_clear2: err=%b, expected 0", timeout_err);
         errors++;
      end
   endtask

   task automatic test_reset_mid_wait();
      int n;
      int snap;
      pulse_man();
      wait_trig(10, n);
      repeat (3) @(negedge sclk);
      checks++;
      if (busy !== 1'b1 || vol_out !== 8'h77) begin
         $display("FAIL rst_pre: busy=%b out=%h, expected 1/77", busy, vol_out);
         errors++;
      end
      nrst = 1'b0;
      #1;
      checks++;
      if ({gs_trig, busy, vol_valid, avg_valid, timeout_err} !== 5'b0 ||
          vol_out !== 8'h00 || vol_avg !== 8'h00 || sample_cnt !== 16'h0) begin
         $display("FAIL rst_mid: trig=%b busy=%b vv=%b av=%b err=%b out=%h avg=%h cnt=%0d, all zero required",
                  gs_trig, busy, vol_valid, avg_valid, timeout_err, vol_out, vol_avg, sample_cnt);
         errors++;
      end
      @(negedge sclk);
      nrst = 1'b1;
      snap = trig_cnt;
      repeat (40) @(negedge sclk);
      checks++;
      if (trig_cnt !== snap) begin
         $display("FAIL rst_no_trig: %0d triggers after reset, expected 0", trig_cnt - snap);
         errors++;
      end
      pulse_man();
      wait_trig(10, n);
      checks++;
      if (n !== 2) begin
         $display("FAIL rst_new_trig: latency %0d, expected 2", n);
         errors++;
      end
      finish_xfer(8'h12, 4);
      checks++;
      if (vol_out !== 8'h12 || sample_cnt !== 16'd1) begin
         $display("FAIL rst_resume: out=%h cnt=%0d, expected 12/1", vol_out, sample_cnt);
         errors++;
      end
   endtask

   initial begin
      nrst      = 1'b0;
      en        = 1'b0;
      auto_mode = 1'b0;
      man_trig  = 1'b0;
      gs_done   = 1'b0;
      vol_in    = 8'h00;
      err_clr   = 1'b0;
      test_reset();
      test_manual();
      test_average();
      test_pending();
      test_auto_period();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
